// File: rtl/bus_fifo_regs.sv
// Register-mapped FIFO with status, level and scratch registers on a simple strobe bus.
// Register reads are combinational; pops, pushes and register writes take effect on the clock edge.
module bus_fifo_regs #(
  parameter int unsigned DATW  = 3,
  parameter int unsigned ADRW  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            do_write,
  input  logic [ADRW-1:0] w_adr,
  input  logic [DATW-1:0] w_data,
  input  logic            do_read,
  input  logic [ADRW-1:0] r_adr,
  output logic [DATW-1:0] read_data,
  output logic [DATW-1:0] fifo_level,
  output logic            not_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATW-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic [DATW-1:0] scratch_q, scratch_d;
  logic            not_empty_q;

  logic empty, full;
  logic wr_fifo, rd_fifo;
  logic push, pop;
  logic err_event, err_clear;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign wr_fifo = do_write && (w_adr[1:0] == 2'd0);
  assign rd_fifo = do_read  && (r_adr[1:0] == 2'd0);

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign pop  = rd_fifo && !empty;
  assign push = wr_fifo && (!full || pop);

  assign err_event = (rd_fifo && empty) || (wr_fifo && full && !pop);
  assign err_clear = do_write && (w_adr[1:0] == 2'd1) && w_data[2];

  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    err_d     = err_q;
    scratch_d = scratch_q;

    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (err_event) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end

    if (do_write && (w_adr[1:0] == 2'd3)) begin
      scratch_d = w_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      scratch_q   <= '0;
      not_empty_q <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      scratch_q   <= scratch_d;
      not_empty_q <= (count_d != '0);
    end
  end

  // Storage is intentionally unreset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && nrst) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  always_comb begin
    read_data = '0;
    unique case (r_adr[1:0])
      2'd0: read_data = empty ? '0 : mem_q[rptr_q];
      2'd1: read_data[2:0] = {err_q, full, empty};
      2'd2: read_data = DATW'(count_q);
      2'd3: read_data = scratch_q;
      default: read_data = '0;
    endcase
  end

  assign fifo_level = DATW'(count_q);
  assign not_empty  = not_empty_q;

endmodule

// File: tb/tb_bus_fifo_regs.sv
// Directed bench for bus_fifo_regs; a queue scoreboard holds the expected FIFO contents.
module tb_bus_fifo_regs;

  logic       clk;
  logic       nrst;
  logic       do_write;
  logic [1:0] w_adr;
  logic [2:0] w_data;
  logic       do_read;
  logic [1:0] r_adr;
  logic [2:0] read_data;
  logic [2:0] fifo_level;
  logic       not_empty;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] q[$];
  logic       err_m;
  logic [2:0] scratch_m;

  bus_fifo_regs #(.DATW(3), .ADRW(2), .DEPTH(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .do_write  (do_write),
    .w_adr     (w_adr),
    .w_data    (w_data),
    .do_read   (do_read),
    .r_adr     (r_adr),
    .read_data (read_data),
    .fifo_level(fifo_level),
    .not_empty (not_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] status_m();
    return {err_m, q.size() == 4, q.size() == 0};
  endfunction

  // One bus cycle: drive at negedge, check pop data combinationally, then update the model.
  task automatic step(input logic we, input logic [1:0] wa, input logic [2:0] wd,
                      input logic re, input logic [1:0] ra, input string tag);
    int   sz;
    logic popped, ev;
    @(negedge clk);
    do_write = we; w_adr = wa; w_data = wd; do_read = re; r_adr = ra;
    #1;
    if (re && ra == 2'd0) check({tag, "_rdata"}, read_data, (q.size() != 0) ? q[0] : 3'd0);
    @(posedge clk);
    #1;
    do_write = 1'b0; do_read = 1'b0;
    sz = q.size(); popped = 1'b0; ev = 1'b0;
    if (re && ra == 2'd0) begin
      if (sz > 0) begin
        void'(q.pop_front());
        popped = 1'b1;
      end else ev = 1'b1;
    end
    if (we && wa == 2'd0) begin
      if (sz < 4 || popped) q.push_back(wd);
      else ev = 1'b1;
    end
    if (ev) err_m = 1'b1;
    else if (we && wa == 2'd1 && wd[2]) err_m = 1'b0;
    if (we && wa == 2'd3) scratch_m = wd;
    check({tag, "_level"}, fifo_level, 3'(q.size()));
    check({tag, "_nempty"}, not_empty, q.size() != 0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [2:0] exp, input string tag);
    @(negedge clk);
    r_adr = a;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    nrst = 1'b0; do_write = 1'b0; w_adr = '0; w_data = '0; do_read = 1'b0; r_adr = 2'd1;
    err_m = 1'b0; scratch_m = '0;
    #3;
    check("rst_level", fifo_level, 3'd0);
    check("rst_nempty", not_empty, 1'b0);
    check("rst_status", read_data, 3'b001);
    @(negedge clk);
    nrst = 1'b1;

    rd(2'd1, 3'b001, "init_status");
    rd(2'd2, 3'd0, "init_level");

    // Fill with 5,2,7,1 then drain in order.
    step(1, 0, 3'd5, 0, 1, "p5");
    step(1, 0, 3'd2, 0, 1, "p2");
    step(1, 0, 3'd7, 0, 1, "p7");
    step(1, 0, 3'd1, 0, 1, "p1");
    rd(2'd1, 3'b010, "full_status");
    rd(2'd2, 3'd4, "full_level");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "pop");
    rd(2'd1, 3'b001, "drained_status");

    // Overflow drops data and sets err; clearing err via status write.
    for (int i = 1; i <= 4; i++) step(1, 0, 3'(i), 0, 1, "fill");
    step(1, 0, 3'd6, 0, 1, "ovf");
    rd(2'd1, status_m(), "ovf_status");
    check("ovf_status_const", read_data, 3'b110);
    step(1, 1, 3'b100, 0, 1, "clr");
    rd(2'd1, 3'b010, "clr_status");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "ovf_pop");

    // Underflow, then simultaneous push/pop on empty.
    step(0, 0, 0, 1, 0, "unf");
    rd(2'd1, 3'b101, "unf_status");
    step(1, 1, 3'b100, 0, 1, "clr2");
    step(1, 0, 3'd3, 1, 0, "pp_empty");
    rd(2'd1, status_m(), "pp_empty_status");
    step(0, 0, 0, 1, 0, "pop3");
    step(1, 1, 3'b100, 0, 1, "clr3");

    // Ten values through the FIFO with interleaved level reads; pointers wrap twice.
    step(1, 0, 3'd4, 0, 2, "wr_pre");
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 3'((i * 3 + 1) % 8), 0, 2, "wr_w");
      rd(2'd2, 3'(q.size()), "wr_lvl");
      step(0, 0, 0, 1, 0, "wr_r");
    end
    while (q.size() < 4) step(1, 0, 3'(q.size() + 2), 0, 1, "topup");
    step(1, 0, 3'd6, 1, 0, "pp_full");
    rd(2'd1, 3'b010, "pp_full_status");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "pp_drain");

    // Scratch, then asynchronous reset between clock edges.
    step(1, 3, 3'b101, 0, 3, "scr");
    rd(2'd3, 3'b101, "scr_rd");
    step(1, 0, 3'd2, 0, 3, "pre_a");
    step(1, 0, 3'd6, 0, 3, "pre_b");
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check("arst_scratch", read_data, 3'd0);
    check("arst_level", fifo_level, 3'd0);
    check("arst_nempty", not_empty, 1'b0);
    q.delete(); err_m = 1'b0; scratch_m = '0;
    @(negedge clk);
    do_write = 1'b1; w_adr = 2'd0; w_data = 3'd7;
    @(posedge clk);
    #1;
    check("arst_ignore", fifo_level, 3'd0);
    do_write = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step(1, 0, 3'd5, 0, 1, "post_rst");
    step(0, 0, 0, 1, 0, "post_pop");
    rd(2'd1, 3'b001, "end_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_fifo_regs.md
BUS_FIFO_REGS -- requirements
Module: bus_fifo_regs

Interface
REQ-001 Parameter DATW, default 3, data width of the bus register port; SHALL be >= 3.
REQ-002 Parameter ADRW, default 2, register address width; only the low 2 address bits are decoded.
REQ-003 Parameter DEPTH, default 4, FIFO depth in entries; SHALL be a power of two and <= 2**DATW - 1.
REQ-004 clk  input  1  single system clock (150 MHz PLL clock); all state changes on its rising edge.
REQ-005 nrst  input  1  asynchronous, active-low reset.
REQ-006 do_write  input  1  one-cycle write strobe from the bus slave.
REQ-007 w_adr  input  ADRW  write register address; valid while do_write=1.
REQ-008 w_data  input  DATW  write data; valid while do_write=1.
REQ-009 do_read  input  1  one-cycle read strobe from the bus slave; marks the read side-effect point.
REQ-010 r_adr  input  ADRW  read register address.
REQ-011 read_data  output  DATW  combinational register read value for r_adr.
REQ-012 fifo_level  output  DATW  current entry count, 0..DEPTH, for LED display.
REQ-013 not_empty  output  1  registered, high while the FIFO holds >= 1 entry.

Function
REQ-014 Register map: 0 = FIFO data (write pushes, read pops); 1 = status; 2 = level (read-only); 3 = scratch (read/write).
REQ-015 Status read value: bit0 empty, bit1 full, bit2 sticky err; all higher bits 0.
REQ-016 read_data SHALL be a purely combinational function of r_adr and current state, valid in the same cycle do_read=1; the bus slave samples it one cycle later.
REQ-017 Read of address 0 with FIFO non-empty: read_data = head entry; when do_read=1 the head SHALL be popped at that clock edge.
REQ-018 Read of address 0 with FIFO empty: read_data = 0; do_read=1 SHALL set err and leave pointers and count unchanged.
REQ-019 Reads with r_adr != 0 SHALL have no side effects; read_data may change with r_adr when do_read=0, with no state change.
REQ-020 Write to address 0 with FIFO not full SHALL store w_data at the tail and increment count at that edge.
REQ-021 Write to address 0 with FIFO full and no simultaneous pop SHALL drop the data and set err; contents are unchanged.
REQ-022 Simultaneous push and pop (do_write to addr 0 and do_read of addr 0 in one cycle): both take effect; count is unchanged; allowed when full.
REQ-023 Simultaneous push and pop when empty: the pop counts as underflow (err set, read_data = 0) and the push proceeds, so count = 1.
REQ-024 Write to address 1 with w_data bit2 = 1 SHALL clear err; other bits are ignored. If an error event occurs in the same cycle, set wins.
REQ-025 Write to address 2 SHALL be ignored.
REQ-026 Write to address 3 SHALL load the scratch register; a read returns it.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-028 count SHALL be log2(DEPTH)+1 bits wide, never exceed DEPTH, and never go below 0.
REQ-029 fifo_level = count zero-extended to DATW, updated at the same edge as count.
REQ-030 not_empty SHALL be high in exactly the cycles where count != 0.
REQ-031 Storage is a DEPTH x DATW register array. Contents are not reset; data is only ever read from valid entries.

Reset
REQ-032 nrst=0 SHALL immediately clear the following regardless of clk: pointers, count, err, scratch, and not_empty.
REQ-033 During reset, outputs SHALL read fifo_level = 0 and not_empty = 0; read_data = status reads 3'b001.
REQ-034 Reset mid-transfer SHALL discard all FIFO contents; do_write and do_read are ignored while nrst=0.
REQ-035 After deassertion, the first strobe SHALL be accepted on the first rising edge with nrst=1.

Verification
REQ-036 Reset, then read addr 1 -> read_data=3'b001; read addr 2 -> 0; not_empty=0.
REQ-037 Push 5,2,7,1 to addr 0 -> status=3'b010, fifo_level=4. Pop four times -> reads 5,2,7,1, then status=3'b001.
REQ-038 Fill to 4, push 6 -> dropped, status=3'b110. Write 3'b100 to addr 1 -> status=3'b010. Pop -> first value unchanged.
REQ-039 Empty FIFO, pop -> read_data=0, err=1, fifo_level stays 0. Simultaneous push 3 + pop on empty -> fifo_level=1, next pop returns 3.
REQ-040 Push/pop 10 values with interleaved level reads (wrap twice) -> data order preserved. Full + simultaneous push/pop -> level stays 4, no err.
REQ-041 Write scratch 3'b101, push 2 entries, assert nrst low mid-sequence -> scratch=0, level=0, not_empty falls without a clk edge.
